// File: rtl/cic_output_scaler.sv
// cic_output_scaler: narrows the bit-grown CIC decimator output to the system
// sample width. Each sample gets a run-time arithmetic right shift, optional
// round-half-up, then signed saturation, through a two-stage AXI-stream
// pipeline with full-throughput backpressure.
// Build option: define CIC_OUTPUT_SCALER_ROUND_EN to add 2^(s-1) before the
// shift (round-half-up); leave it undefined for floor truncation.
module cic_output_scaler #(
    parameter int unsigned IN_WIDTH  = 18,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned SHIFT_MAX = 8,
    parameter int unsigned CNT_WIDTH = 16,
    localparam int unsigned SHIFT_W  = $clog2(SHIFT_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  input_tdata,
    input  logic                 input_tvalid,
    output logic                 input_tready,
    output logic [OUT_WIDTH-1:0] output_tdata,
    output logic                 output_tvalid,
    input  logic                 output_tready,
    input  logic [SHIFT_W-1:0]   shift,
    input  logic                 clear_sat,
    output logic                 sat_flag,
    output logic [CNT_WIDTH-1:0] sat_count
);

    // Stage-1 width: one guard bit so the rounding addend cannot overflow.
    localparam int unsigned W1   = IN_WIDTH + 1;
    localparam int unsigned HEAD = W1 - OUT_WIDTH + 1;

    localparam logic [SHIFT_W-1:0]  SHIFT_LIM = SHIFT_W'(SHIFT_MAX);
    localparam logic signed [W1-1:0] SAT_HI = {{HEAD{1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [W1-1:0] SAT_LO = {{HEAD{1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] OUT_HI = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_LO = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic                  v1_q, v1_d;
    logic signed [W1-1:0]  d1_q, d1_d;
    logic                  v2_q, v2_d;
    logic [OUT_WIDTH-1:0]  d2_q, d2_d;
    logic                  flag_q, flag_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  load1, load2;
    logic [SHIFT_W-1:0]    s_eff;
    logic signed [W1-1:0]  ext, addend, sum, shifted;
    logic                  over_hi, under_lo, sat_event;

    assign load2        = ~v2_q | output_tready;
    assign load1        = ~v1_q | load2;
    assign input_tready = load1;

    assign output_tdata  = d2_q;
    assign output_tvalid = v2_q;
    assign sat_flag      = flag_q;
    assign sat_count     = cnt_q;

    // Stage-1 arithmetic: clamp shift, sign-extend, optional rounding, shift.
    always_comb begin
        s_eff = (shift > SHIFT_LIM) ? SHIFT_LIM : shift;
        ext   = {input_tdata[IN_WIDTH-1], input_tdata};
`ifdef CIC_OUTPUT_SCALER_ROUND_EN
        addend = (W1'(1) << s_eff) >> 1;
`else
        addend = '0;
`endif
        sum     = ext + addend;
        shifted = sum >>> s_eff;
    end

    // Stage-2 range detection on the registered stage-1 value.
    always_comb begin
        over_hi   = d1_q > SAT_HI;
        under_lo  = d1_q < SAT_LO;
        sat_event = load2 & v1_q & (over_hi | under_lo);
    end

    // Next-state for both pipeline stages; data only moves on a load.
    always_comb begin
        v1_d = v1_q;
        d1_d = d1_q;
        v2_d = v2_q;
        d2_d = d2_q;
        if (load1) begin
            v1_d = input_tvalid;
            if (input_tvalid) begin
                d1_d = shifted;
            end
        end
        if (load2) begin
            v2_d = v1_q;
            if (v1_q) begin
                if (over_hi) begin
                    d2_d = OUT_HI;
                end else if (under_lo) begin
                    d2_d = OUT_LO;
                end else begin
                    d2_d = d1_q[OUT_WIDTH-1:0];
                end
            end
        end
    end

    // Saturation statistics; a clear in the same cycle as an event wins.
    always_comb begin
        flag_d = flag_q;
        cnt_d  = cnt_q;
        if (clear_sat) begin
            flag_d = 1'b0;
            cnt_d  = '0;
        end else if (sat_event) begin
            flag_d = 1'b1;
            if (!(&cnt_q)) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            d1_q   <= '0;
            v2_q   <= 1'b0;
            d2_q   <= '0;
            flag_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            v1_q   <= v1_d;
            d1_q   <= d1_d;
            v2_q   <= v2_d;
            d2_q   <= d2_d;
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: doc/cic_output_scaler.md
# cic_output_scaler

- Sits directly downstream of the CIC decimator and narrows its bit-grown output to the system sample width.
- Per sample: arithmetic right shift by a run-time amount, optional round-half-up, signed saturation.
- Two-stage AXI-stream pipeline with full-throughput backpressure; reports saturation events through a sticky flag and a saturating counter.

## Interface
Parameters:
- IN_WIDTH, default 18: signed input width; matches decimator REG_WIDTH for WIDTH=16, RMAX=2, N=2.
- OUT_WIDTH, default 16: signed output width; must be ≤ IN_WIDTH.
- SHIFT_MAX, default 8: largest legal shift.
- CNT_WIDTH, default 16: width of the saturation counter.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- input_tdata  input  IN_WIDTH  signed sample from decimator.
- input_tvalid  input  1  input sample valid.
- input_tready  output  1  block can accept a sample this cycle.
- output_tdata  output  OUT_WIDTH  scaled signed sample.
- output_tvalid  output  1  output sample valid.
- output_tready  input  1  downstream accepts.
- shift  input  $clog2(SHIFT_MAX+1)  right-shift amount; values > SHIFT_MAX clamp to SHIFT_MAX.
- clear_sat  input  1  synchronous clear of sat_flag and sat_count.
- sat_flag  output  1  sticky: at least one sample saturated since last clear.
- sat_count  output  CNT_WIDTH  number of saturated samples; holds at all-ones.

## Operation
- Input transfer occurs on input_tvalid & input_tready. shift is captured with the sample and travels with it; a shift change affects only later samples.
- Stage 1 (on accept): sign-extend input to IN_WIDTH+1 bits, add 2^(s-1) when s>0 (rounding, see Configuration), arithmetic right shift by s. Register result and valid bit v1.
- Stage 2: compare stage-1 value against [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Above range → max positive; below range → min negative; otherwise take low OUT_WIDTH bits.
  - Register the result as output_tdata/output_tvalid (v2) plus a per-sample sat bit.
- Pipeline advance:
  - Stage 2 loads when !v2 | output_tready.
  - Stage 1 loads when !v1 | stage 2 loads.
  - input_tready = !v1 | !v2 | output_tready (combinational from output_tready and state only).
- Saturation stats update when a saturated sample enters stage 2:
  - sat_flag <= 1.
  - sat_count increments unless already all-ones.
- clear_sat asserted in the same cycle as a saturation event: clear wins; flag and count become 0.
- No data dropped or reordered under any tvalid/tready pattern.
- output_tdata holds stable while output_tvalid & !output_tready.

## Timing
- Latency: accepted input appears on output_tdata/output_tvalid 2 cycles later with output_tready held high.
- Throughput: 1 sample/cycle sustained.
- Capacity: 2 samples buffered under backpressure.
- Reset (rst_n low, any time incl. mid-stream):
  - Takes effect immediately, asynchronously.
  - output_tvalid=0, output_tdata=0, sat_flag=0, sat_count=0, v1=0, all pipeline data 0.
  - input_tready=1 after reset.
  - In-flight samples discarded.
- Deassertion of rst_n is synchronised externally; the first accept is allowed on the first clock edge after release.

## Configuration
- Macro CIC_OUTPUT_SCALER_ROUND_EN.
- Defined: stage 1 adds 2^(s-1) before shifting, giving round-half-up; s=0 adds nothing.
- Undefined: no addend, giving truncation toward −∞ (floor).
- Saturation and handshake behaviour are identical in both builds.

## Test plan
- Rounding (shift=2), inputs 6, 5, −6 → ROUND_EN: 2, 1, −1; without ROUND_EN: 1, 1, −2. Each at exactly 2-cycle latency.
- Saturation (shift=0), inputs 40000, −40000, 32767:
  - Outputs 32767, −32768, 32767.
  - sat_flag=1, sat_count=2.
  - Pulse clear_sat → both 0 next cycle.
- Backpressure (shift=1):
  - Stream 1..10 with output_tready low for cycles 3–8.
  - input_tready drops after 2 samples are buffered.
  - Outputs are exactly the shifted 1..10 in order; no duplicates or gaps.
- Counter wrap: CNT_WIDTH=4, 20 saturating samples → sat_count holds 15. Simultaneous clear_sat and saturation → count 0.
- Shift change mid-stream: samples 1024 (shift 2) then 1024 (shift 4) back-to-back → outputs 256 then 64. shift=15 clamps to 8: 1024 → 4.
- Reset mid-stream: rst_n low with both stages full → output_tvalid and sat_flag drop to 0 without a clock edge. After release, input 100 (shift 0) → output 100 two cycles later.
